// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM command monitor: command codes, error causes and FSM states.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_NOP           = 4'd0,
        CMD_MODE_REG_SET  = 4'd1,
        CMD_ACTIVE        = 4'd2,
        CMD_READ          = 4'd3,
        CMD_WRITE         = 4'd4,
        CMD_AUTO_REFRESH  = 4'd5,
        CMD_PRECHARGE     = 4'd6,
        CMD_PRECHARGE_ALL = 4'd7,
        CMD_BURST_TERM    = 4'd8
    } CmdType;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ILLEGAL   = 3'd1,
        ERR_NOT_INIT  = 3'd2,
        ERR_TRFC_VIOL = 3'd3,
        ERR_BANK_OPEN = 3'd4,
        ERR_ACT_OPEN  = 3'd5,
        ERR_RW_CLOSED = 3'd6,
        ERR_TRCD_VIOL = 3'd7
    } ErrType;

    typedef enum logic [1:0] {
        ST_UNINIT  = 2'd0,
        ST_READY   = 2'd1,
        ST_REFRESH = 2'd2
    } FsmState;

    function automatic logic is_legal_cmd(input logic [3:0] code);
        return code <= 4'(CMD_BURST_TERM);
    endfunction

endpackage

// File: rtl/sdram_cmd_monitor_if.sv
// Command bus plus monitor status; the controller side is master, the monitor is slave.
interface sdram_cmd_monitor_if #(
    parameter int NUM_BANKS = 4
) ();
    localparam int BW = $clog2(NUM_BANKS);

    logic [3:0]           command;
    logic [BW-1:0]        bank;
    logic [NUM_BANKS-1:0] bank_active;
    logic                 initialized;
    logic                 refresh_busy;
    logic [15:0]          refresh_count;
    logic                 err_valid;
    logic [2:0]           err_code;

    modport master (
        output command, bank,
        input  bank_active, initialized, refresh_busy, refresh_count, err_valid, err_code
    );

    modport slave (
        input  command, bank,
        output bank_active, initialized, refresh_busy, refresh_count, err_valid, err_code
    );
endinterface

// File: rtl/sdram_cmd_monitor_flex_counter.sv
// Up-counter with synchronous clear that wraps to 0 after rollover_val; flag is high at rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
    end

    assign rollover_flag = (count_out == rollover_val);
endmodule

// File: rtl/sdram_cmd_monitor.sv
// SDRAM command protocol monitor: bank/refresh tracking with tRCD/tRFC checks.
// Define SDRAM_ERR_STICKY_EN to latch the first error until reset instead of pulsing per error.
module sdram_cmd_monitor
    import sdram_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int TRFC      = 9,
    parameter int TRCD      = 3
) (
    input logic                clk,
    input logic                n_rst,
    sdram_cmd_monitor_if.slave bus
);
    localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int CW = (TRFC > 1) ? $clog2(TRFC) : 1;

    localparam logic [1:0] S_UNINIT  = 2'(ST_UNINIT);
    localparam logic [1:0] S_READY   = 2'(ST_READY);
    localparam logic [1:0] S_REFRESH = 2'(ST_REFRESH);

    logic [1:0]           state, state_next;
    logic [NUM_BANKS-1:0] open_q, open_next;
    logic [NUM_BANKS-1:0] trcd_busy;
    logic                 init_q, init_set;
    logic [15:0]          ref_cnt_q;
    logic                 rfc_start, act_load;
    logic [CW-1:0]        rfc_count;
    logic                 rfc_done;
    logic                 err_valid_q;
    logic [2:0]           err_code_q;
    ErrType               err_now;
    logic                 rw_cmd;

    // Classify the sampled command; the chain is ordered so the lowest error code wins.
    always_comb begin
        err_now = ERR_NONE;
        rw_cmd  = (bus.command == CMD_READ) || (bus.command == CMD_WRITE);
        if (!is_legal_cmd(bus.command))
            err_now = ERR_ILLEGAL;
        else if (state == S_REFRESH) begin
            if (bus.command != CMD_NOP)
                err_now = ERR_TRFC_VIOL;
        end else if (state == S_READY) begin
            if (((bus.command == CMD_AUTO_REFRESH) || (bus.command == CMD_MODE_REG_SET)) && (|open_q))
                err_now = ERR_BANK_OPEN;
            else if ((bus.command == CMD_ACTIVE) && open_q[bus.bank])
                err_now = ERR_ACT_OPEN;
            else if (rw_cmd && !open_q[bus.bank])
                err_now = ERR_RW_CLOSED;
            else if (rw_cmd && trcd_busy[bus.bank])
                err_now = ERR_TRCD_VIOL;
        end else if ((bus.command != CMD_NOP) && (bus.command != CMD_MODE_REG_SET))
            err_now = ERR_NOT_INIT;
    end

    // Erroring commands leave state untouched; the refresh window ages regardless of the command.
    always_comb begin
        state_next = state;
        open_next  = open_q;
        init_set   = 1'b0;
        rfc_start  = 1'b0;
        act_load   = 1'b0;
        case (state)
            S_UNINIT: begin
                if (bus.command == CMD_MODE_REG_SET) begin
                    state_next = S_READY;
                    init_set   = 1'b1;
                end
            end
            S_READY: begin
                if (err_now == ERR_NONE) begin
                    case (bus.command)
                        CMD_AUTO_REFRESH: begin
                            state_next = S_REFRESH;
                            rfc_start  = 1'b1;
                        end
                        CMD_ACTIVE: begin
                            open_next[bus.bank] = 1'b1;
                            act_load            = 1'b1;
                        end
                        CMD_PRECHARGE:     open_next[bus.bank] = 1'b0;
                        CMD_PRECHARGE_ALL: open_next = '0;
                        default: ;
                    endcase
                end
            end
            S_REFRESH: begin
                if ((bus.command == CMD_NOP) && rfc_done)
                    state_next = S_READY;
            end
            default: state_next = S_UNINIT;
        endcase
    end

    flex_counter #(.NUM_CNT_BITS(CW)) u_rfc_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (rfc_start),
        .count_enable ((state == S_REFRESH) && (rfc_count != CW'(TRFC - 1))),
        .rollover_val (CW'(TRFC - 1)),
        .count_out    (rfc_count),
        .rollover_flag(rfc_done)
    );

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_trcd
        logic [TW-1:0] trcd_cnt;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)
                trcd_cnt <= '0;
            else if (act_load && (bus.bank == ($bits(bus.bank))'(i)))
                trcd_cnt <= TW'(TRCD - 1);
            else if (trcd_cnt != '0)
                trcd_cnt <= trcd_cnt - TW'(1);
        end

        assign trcd_busy[i] = (trcd_cnt != '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_UNINIT;
            open_q    <= '0;
            init_q    <= 1'b0;
            ref_cnt_q <= '0;
        end else begin
            state  <= state_next;
            open_q <= open_next;
            if (init_set)
                init_q <= 1'b1;
            if (rfc_start)
                ref_cnt_q <= ref_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
`ifdef SDRAM_ERR_STICKY_EN
            if (!err_valid_q && (err_now != ERR_NONE)) begin
                err_valid_q <= 1'b1;
                err_code_q  <= err_now;
            end
`else
            err_valid_q <= (err_now != ERR_NONE);
            err_code_q  <= err_now;
`endif
        end
    end

    assign bus.bank_active   = open_q;
    assign bus.initialized   = init_q;
    assign bus.refresh_busy  = (state == S_REFRESH);
    assign bus.refresh_count = ref_cnt_q;
    assign bus.err_valid     = err_valid_q;
    assign bus.err_code      = err_code_q;
endmodule
